// File: rtl/btn_debounce_counter_if.sv
// Button debouncer / press counter signal bundle.
// The master drives the sampled inputs; the slave (the debouncer) drives the results.
interface btn_debounce_counter_if #(
    parameter int unsigned DIGITS = 4
) ();
    logic                  tick_in;
    logic                  btn_in;
    logic                  clr;
    logic                  press_pulse;
    logic                  btn_state;
    logic [4*DIGITS-1:0]   count;
    logic                  overflow;

    modport master (
        output tick_in,
        output btn_in,
        output clr,
        input  press_pulse,
        input  btn_state,
        input  count,
        input  overflow
    );

    modport slave (
        input  tick_in,
        input  btn_in,
        input  clr,
        output press_pulse,
        output btn_state,
        output count,
        output overflow
    );
endinterface

// File: rtl/btn_debounce_counter.sv
// Debounces a raw button using the divider's slow square wave as a sample strobe,
// and keeps a BCD count of accepted presses. Everything runs on CLK_in.
module btn_debounce_counter #(
    parameter int unsigned STABLE_TICKS = 4,
    parameter int unsigned DIGITS       = 4
) (
    input  logic                    CLK_in,
    input  logic                    RST,
    btn_debounce_counter_if.slave   bus
);

    localparam logic [3:0] StableCnt = 4'(STABLE_TICKS);

    typedef enum logic [1:0] {
        StIdle,
        StDebPress,
        StPressed,
        StDebRelease
    } state_e;

    logic                r_btn_meta;
    logic                r_btn_s;
    logic                r_tick_meta;
    logic                r_tick_s;
    logic                r_tick_prev;
    state_e              r_state;
    logic [3:0]          r_cnt;
    logic                r_press;
    logic                r_btn_state;
    logic [4*DIGITS-1:0] r_count;
    logic                r_overflow;

    logic                w_sample_en;
    logic [3:0]          w_cnt_inc;
    logic [4*DIGITS-1:0] w_count_inc;
    logic                w_wrap;

    // Tick is treated as data: synchronise it and detect its rising edge.
    always_ff @(posedge CLK_in) begin
        if (RST) begin
            r_btn_meta  <= 1'b0;
            r_btn_s     <= 1'b0;
            r_tick_meta <= 1'b0;
            r_tick_s    <= 1'b0;
            r_tick_prev <= 1'b0;
        end else begin
            r_btn_meta  <= bus.btn_in;
            r_btn_s     <= r_btn_meta;
            r_tick_meta <= bus.tick_in;
            r_tick_s    <= r_tick_meta;
            r_tick_prev <= r_tick_s;
        end
    end

    assign w_sample_en = r_tick_s & ~r_tick_prev;
    assign w_cnt_inc   = r_cnt + 4'd1;

    always_ff @(posedge CLK_in) begin
        if (RST) begin
            r_state     <= StIdle;
            r_cnt       <= 4'd0;
            r_press     <= 1'b0;
            r_btn_state <= 1'b0;
        end else begin
            r_press <= 1'b0;
            if (w_sample_en) begin
                case (r_state)
                    StIdle: begin
                        if (r_btn_s) begin
                            if (StableCnt == 4'd1) begin
                                r_state     <= StPressed;
                                r_cnt       <= 4'd0;
                                r_press     <= 1'b1;
                                r_btn_state <= 1'b1;
                            end else begin
                                r_state <= StDebPress;
                                r_cnt   <= 4'd1;
                            end
                        end else begin
                            r_cnt <= 4'd0;
                        end
                    end
                    StDebPress: begin
                        if (r_btn_s) begin
                            if (w_cnt_inc == StableCnt) begin
                                r_state     <= StPressed;
                                r_cnt       <= 4'd0;
                                r_press     <= 1'b1;
                                r_btn_state <= 1'b1;
                            end else begin
                                r_cnt <= w_cnt_inc;
                            end
                        end else begin
                            r_state <= StIdle;
                            r_cnt   <= 4'd0;
                        end
                    end
                    StPressed: begin
                        if (!r_btn_s) begin
                            if (StableCnt == 4'd1) begin
                                r_state     <= StIdle;
                                r_cnt       <= 4'd0;
                                r_btn_state <= 1'b0;
                            end else begin
                                r_state <= StDebRelease;
                                r_cnt   <= 4'd1;
                            end
                        end else begin
                            r_cnt <= 4'd0;
                        end
                    end
                    StDebRelease: begin
                        if (!r_btn_s) begin
                            if (w_cnt_inc == StableCnt) begin
                                r_state     <= StIdle;
                                r_cnt       <= 4'd0;
                                r_btn_state <= 1'b0;
                            end else begin
                                r_cnt <= w_cnt_inc;
                            end
                        end else begin
                            r_state <= StPressed;
                            r_cnt   <= 4'd0;
                        end
                    end
                    default: begin
                        r_state     <= StIdle;
                        r_cnt       <= 4'd0;
                        r_btn_state <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Ripple BCD increment; w_wrap is set when every digit was 9.
    always_comb begin
        logic       carry;
        logic [3:0] digit;
        carry       = 1'b1;
        w_count_inc = r_count;
        for (int i = 0; i < int'(DIGITS); i++) begin
            digit = r_count[4*i +: 4];
            if (carry) begin
                if (digit >= 4'd9) begin
                    w_count_inc[4*i +: 4] = 4'd0;
                end else begin
                    w_count_inc[4*i +: 4] = digit + 4'd1;
                    carry                 = 1'b0;
                end
            end
        end
        w_wrap = carry;
    end

    always_ff @(posedge CLK_in) begin
        if (RST) begin
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= 1'b0;
            if (bus.clr) begin
                r_count <= '0;
            end else if (r_press) begin
                r_count    <= w_count_inc;
                r_overflow <= w_wrap;
            end
        end
    end

    assign bus.press_pulse = r_press;
    assign bus.btn_state   = r_btn_state;
    assign bus.count       = r_count;
    assign bus.overflow    = r_overflow;

endmodule
